down_avg_decim: RTL and testbench
=================================

Name: down_avg_decim

Overview:
- Sits directly downstream of the running averager in the AddDivideChop chain.
- Consumes that averager's N-bit unsigned output stream and block-averages non-overlapping windows of R = 2^LOG2_R samples, emitting one result per window (decimate by R).
- Presents results on a valid/ready interface toward the chop/readout stage.
- Flags and counts results lost to backpressure.

Parameters:
- N, 16, sample width in bits; input and output are both N bits.
- LOG2_R, 1, log2 of the decimation ratio R; legal range 1..8, otherwise elaboration error.
- DROP_W, 8, width of the dropped-result counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- x  in  N  unsigned input sample from the averager.
- x_valid  in  1  x is a valid sample this cycle.
- clear  in  1  abandon the current window and restart accumulation; does not affect the output register.
- y  out  N  decimated average.
- y_valid  out  1  y holds an unconsumed result.
- y_ready  in  1  downstream accepts y this cycle.
- overrun  out  1  sticky: at least one result was dropped.
- drop_cnt  out  DROP_W  number of dropped results, saturating at all-ones.

Behaviour:
- Reset is synchronous, active-low: rst_n sampled low at a rising edge of clk clears state.
- Reset values: acc=0, cnt=0, y=0, y_valid=0, overrun=0, drop_cnt=0. Reset mid-window discards the partial sum and any pending y.
- Accumulator: width N+LOG2_R, so it never overflows.
- Window counter cnt: LOG2_R bits, counts 0..R-1.
- ACCUM, x_valid=1 and cnt<R-1: acc<=acc+x; cnt<=cnt+1.
- DONE, x_valid=1 and cnt==R-1:
  - sum = acc+x, width N+LOG2_R.
  - result = sum>>LOG2_R (truncate; see Optional Feature).
  - acc<=0; cnt<=0; a result is produced this edge.
- x_valid=0: acc and cnt hold. Gaps are allowed anywhere in a window.
- clear=1: acc<=0 and cnt<=0, and the sample x presented that cycle is discarded even if x_valid=1. clear has priority over accumulation. y, y_valid, overrun and drop_cnt are unaffected.
- Latency: y_valid rises on the clock edge that accepts the R-th sample. y is visible the cycle after that sample is presented.
- Output register, single entry; pop = y_valid & y_ready:
  - Result produced, no y_valid: y<=result; y_valid<=1.
  - Result produced with a simultaneous pop: y<=result; y_valid stays 1. This is not an overrun.
  - Result produced, y_valid=1 and y_ready=0: the new result is dropped, y is held, overrun<=1, drop_cnt<=drop_cnt+1 saturating.
  - Pop with no new result: y_valid<=0; y holds its old value.
- y changes only when a new result is loaded. y_valid never drops without a pop or a reset.
- Max input: R samples of 2^N-1 average to exactly 2^N-1. There is no saturation logic in the truncating path.
- overrun and drop_cnt clear only on reset.

Optional Feature:
- Macro: DOWN_AVG_DECIM_ROUND_EN.
- Defined: result = (sum + 2^(LOG2_R-1)) >> LOG2_R, computed at N+LOG2_R+1 bits and saturated to 2^N-1 (round half up).
- Undefined: plain truncation, result = sum>>LOG2_R, with no rounding adder or saturation logic.

Test Plan:
- Basic window: LOG2_R=1, y_ready=1. x=10 then x=20 with x_valid=1 on consecutive cycles -> y=15 with y_valid=1 for exactly one cycle, starting the cycle after x=20 is accepted.
- Ramp: x=0..1023 on consecutive cycles, y_ready=1 -> 512 results y=0,2,4,...,1022 (truncated). With ROUND_EN defined -> y=1,3,5,...,1023, the last saturating-safe.
- Full scale: x=16'hFFFF for 8 cycles -> four results of 16'hFFFF, both with and without ROUND_EN; overrun stays 0.
- Backpressure: y_ready=0, feed 6 samples of 4 -> first result y=4 held. The second and third results are dropped -> overrun=1, drop_cnt=2. Raise y_ready -> y=4 pops and y_valid falls the next cycle.
- Simultaneous pop and new result: y_valid=1 with y_ready=1 on the same edge a new result of 7 completes -> y=7, y_valid stays 1, drop_cnt unchanged.
- Gaps, clear and reset mid-window:
  - x=100 (valid), 2 idle cycles, x=200 -> y=150.
  - x=100, then clear with x=999 valid, then x=2, x=4 -> y=3.
  - x=100, then rst_n low for 1 cycle, then x=6, x=8 -> y=7, with all outputs 0 during reset.

Source files
------------

// File: rtl/down_avg_decim.sv
// Block-averaging decimator: sums windows of 2^LOG2_R samples and emits one average per window
// on a single-entry valid/ready register. Define DOWN_AVG_DECIM_ROUND_EN for round-half-up results.
module down_avg_decim #(
    parameter int N      = 16,
    parameter int LOG2_R = 1,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      x,
    input  logic              x_valid,
    input  logic              clear,
    output logic [N-1:0]      y,
    output logic              y_valid,
    input  logic              y_ready,
    output logic              overrun,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int AW = N + LOG2_R;

    generate
        if (LOG2_R < 1 || LOG2_R > 8) begin : g_bad_log2_r
            $error("down_avg_decim: LOG2_R must be in 1..8");
        end
    endgenerate

    logic [AW-1:0]     acc_q, acc_d;
    logic [LOG2_R-1:0] cnt_q, cnt_d;
    logic [AW-1:0]     sum;
    logic              done;
    logic [N-1:0]      result;

    logic [N-1:0]      y_q, y_d;
    logic              y_valid_q, y_valid_d;
    logic              overrun_q, overrun_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    // Window accumulation; clear wins over an incoming sample.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        done  = 1'b0;
        sum   = acc_q + {{LOG2_R{1'b0}}, x};
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (x_valid) begin
            if (&cnt_q) begin
                done  = 1'b1;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + LOG2_R'(1);
            end
        end
    end

`ifdef DOWN_AVG_DECIM_ROUND_EN
    localparam logic [AW:0] HALF = (AW+1)'(1) << (LOG2_R - 1);
    logic [AW:0] rsum;
    logic [AW:0] rshift;

    // The extra bit catches the carry from rounding a full-scale window.
    always_comb begin
        rsum   = {1'b0, sum} + HALF;
        rshift = rsum >> LOG2_R;
        result = (|rshift[AW:N]) ? '1 : rshift[N-1:0];
    end
`else
    assign result = sum[AW-1:LOG2_R];
`endif

    // A result arriving while the register is full and not being popped is lost.
    always_comb begin
        y_d        = y_q;
        y_valid_d  = y_valid_q;
        overrun_d  = overrun_q;
        drop_cnt_d = drop_cnt_q;
        if (done) begin
            if (!y_valid_q || y_ready) begin
                y_d       = result;
                y_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + DROP_W'(1);
                end
            end
        end else if (y_valid_q && y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            y_q        <= '0;
            y_valid_q  <= 1'b0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign overrun  = overrun_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_down_avg_decim.sv
// Directed bench for down_avg_decim: a window/queue-level model checked every cycle,
// plus hand-computed literal expectations at the key points of each scenario.
module tb_down_avg_decim;

    localparam int N      = 16;
    localparam int LOG2_R = 1;
    localparam int DROP_W = 8;
    localparam int R      = 1 << LOG2_R;
    localparam longint MAXV  = (longint'(1) << N) - 1;
    localparam int DROP_MAX  = (1 << DROP_W) - 1;
`ifdef DOWN_AVG_DECIM_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      x = '0;
    logic              x_valid = 1'b0;
    logic              clear = 1'b0;
    logic [N-1:0]      y;
    logic              y_valid;
    logic              y_ready = 1'b0;
    logic              overrun;
    logic [DROP_W-1:0] drop_cnt;

    int checks   = 0;
    int failures = 0;
    int pop_cnt  = 0;
    bit chk_en   = 1'b0;

    down_avg_decim #(.N(N), .LOG2_R(LOG2_R), .DROP_W(DROP_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x        (x),
        .x_valid  (x_valid),
        .clear    (clear),
        .y        (y),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .overrun  (overrun),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Model: the samples of the open window live in a queue; a full window is averaged arithmetically.
    longint win_q[$];
    longint m_y;
    bit     m_yv;
    bit     m_ov;
    int     m_drop;
    bit     m_prod;
    longint m_res;
    longint m_total;

    function automatic longint avg_of(input longint total);
        longint r;
        if (ROUND) begin
            r = (total + R / 2) / R;
            if (r > MAXV) r = MAXV;
        end else begin
            r = total / R;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            win_q.delete();
            m_y = 0; m_yv = 0; m_ov = 0; m_drop = 0;
        end else begin
            m_prod = 0;
            if (clear) begin
                win_q.delete();
            end else if (x_valid) begin
                win_q.push_back(longint'(x));
                if (win_q.size() == R) begin
                    m_total = 0;
                    foreach (win_q[i]) m_total += win_q[i];
                    m_res  = avg_of(m_total);
                    m_prod = 1;
                    win_q.delete();
                end
            end
            if (m_prod) begin
                if (!m_yv || y_ready) begin
                    m_y = m_res; m_yv = 1;
                end else begin
                    m_ov = 1;
                    if (m_drop < DROP_MAX) m_drop++;
                end
            end else if (m_yv && y_ready) begin
                m_yv = 0;
            end
        end
    end

    task automatic cmp(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("y_valid", longint'(y_valid), longint'(m_yv));
            cmp("y", longint'(y), m_y);
            cmp("overrun", longint'(overrun), longint'(m_ov));
            cmp("drop_cnt", longint'(drop_cnt), longint'(m_drop));
            if (y_valid && y_ready) begin
                pop_cnt++;
                $display("pop y=%0d drop_cnt=%0d overrun=%0d t=%0t", y, drop_cnt, overrun, $time);
            end
        end
    end

    task automatic step(input logic v, input logic [N-1:0] xi, input logic clr, input logic rdy);
        x_valid = v; x = xi; clear = clr; y_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    int p0;

    initial begin
        rst_n = 1'b0;
        step(0, '0, 0, 0);
        chk_en = 1'b1;
        step(0, '0, 0, 0);
        cmp("rst_y", longint'(y), 0);
        cmp("rst_y_valid", longint'(y_valid), 0);
        cmp("rst_overrun", longint'(overrun), 0);
        cmp("rst_drop_cnt", longint'(drop_cnt), 0);
        rst_n = 1'b1;

        // Basic window
        step(1, 16'd10, 0, 1);
        cmp("basic_not_yet", longint'(y_valid), 0);
        step(1, 16'd20, 0, 1);
        cmp("basic_valid", longint'(y_valid), 1);
        cmp("basic_y", longint'(y), 15);
        step(0, '0, 0, 1);
        cmp("basic_pop", longint'(y_valid), 0);
        cmp("basic_y_hold", longint'(y), 15);

        // Ramp
        p0 = pop_cnt;
        for (int i = 0; i < 1024; i++) step(1, N'(i), 0, 1);
        step(0, '0, 0, 1);
        cmp("ramp_results", longint'(pop_cnt - p0), 512);
        cmp("ramp_last_y", longint'(y), ROUND ? 1023 : 1022);

        // Full scale
        for (int i = 0; i < 8; i++) step(1, '1, 0, 1);
        cmp("full_y", longint'(y), 65535);
        cmp("full_valid", longint'(y_valid), 1);
        cmp("full_overrun", longint'(overrun), 0);
        step(0, '0, 0, 1);

        // Backpressure
        for (int i = 0; i < 6; i++) step(1, 16'd4, 0, 0);
        cmp("bp_valid", longint'(y_valid), 1);
        cmp("bp_y", longint'(y), 4);
        cmp("bp_overrun", longint'(overrun), 1);
        cmp("bp_drop_cnt", longint'(drop_cnt), 2);
        step(0, '0, 0, 1);
        cmp("bp_pop_valid", longint'(y_valid), 0);
        cmp("bp_pop_y", longint'(y), 4);

        // Simultaneous pop and new result
        step(1, 16'd2, 0, 0);
        step(1, 16'd2, 0, 0);
        cmp("sim_first_y", longint'(y), 2);
        step(1, 16'd6, 0, 0);
        step(1, 16'd8, 0, 1);
        cmp("sim_y", longint'(y), 7);
        cmp("sim_valid", longint'(y_valid), 1);
        cmp("sim_drop_cnt", longint'(drop_cnt), 2);
        step(0, '0, 0, 1);

        // Gaps
        step(1, 16'd100, 0, 1);
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);
        step(1, 16'd200, 0, 1);
        cmp("gap_y", longint'(y), 150);
        step(0, '0, 0, 1);

        // Clear discards the partial window and the sample presented with it
        step(1, 16'd100, 0, 1);
        step(1, 16'd999, 1, 1);
        step(1, 16'd2, 0, 1);
        cmp("clr_no_result", longint'(y_valid), 0);
        step(1, 16'd4, 0, 1);
        cmp("clr_y", longint'(y), 3);
        step(0, '0, 0, 1);

        // Reset mid-window
        step(1, 16'd100, 0, 1);
        rst_n = 1'b0;
        step(0, '0, 0, 1);
        cmp("mrst_y", longint'(y), 0);
        cmp("mrst_valid", longint'(y_valid), 0);
        cmp("mrst_overrun", longint'(overrun), 0);
        cmp("mrst_drop_cnt", longint'(drop_cnt), 0);
        rst_n = 1'b1;
        step(1, 16'd6, 0, 1);
        step(1, 16'd8, 0, 1);
        cmp("mrst_y7", longint'(y), 7);
        cmp("mrst_valid7", longint'(y_valid), 1);
        step(0, '0, 0, 1);

        // Drop counter saturation: 260 results, one kept, 259 dropped
        for (int i = 0; i < 2 * 260; i++) step(1, 16'd1, 0, 0);
        cmp("sat_drop_cnt", longint'(drop_cnt), DROP_MAX);
        cmp("sat_overrun", longint'(overrun), 1);
        cmp("sat_y", longint'(y), 1);
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
